// File: rtl/operand_fetch_stage_pkg.sv
// Shared types and constants for the operand fetch stage.
// Register map constants, widths and the issued-instruction bundle.
package operand_fetch_stage_pkg;

   localparam int NUM_GPR  = 29;
   localparam int DATA_W   = 32;
   localparam int MAX_PEND = 5;
   localparam int CTRL_W   = 16;
   localparam int REG_W    = 5;
   localparam int PEND_W   = 3;

   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;
   localparam logic [REG_W-1:0] LO_REG   = 5'd30;
   localparam logic [REG_W-1:0] HI_REG   = 5'd31;

   typedef logic [REG_W-1:0]  reg_t;
   typedef logic [PEND_W-1:0] pend_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      data_t             rs_data;
      data_t             rt_data;
      reg_t              rd;
      logic              wr_rd;
      logic              wr_hilo;
   } issue_t;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

   function automatic logic is_gpr(reg_t r);
      return (r != ZERO_REG) && (r < LO_REG);
   endfunction

endpackage

// File: rtl/operand_fetch_stage_reg_scoreboard_file.sv
// Register file with per-register pending-write counters.
// Ports: 2 bypassed read ports, busy/full queries, issue inc, writeback, wb_err_o.
module reg_scoreboard_file
   import operand_fetch_stage_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  reg_t  rs_i,
   input  reg_t  rt_i,
   output data_t rs_data_o,
   output data_t rt_data_o,
   output logic  rs_busy_o,
   output logic  rt_busy_o,
   input  reg_t  chk_rd_i,
   output logic  rd_full_o,
   output logic  hilo_full_o,
   input  logic  inc_rd_en_i,
   input  reg_t  inc_rd_i,
   input  logic  inc_hilo_i,
   input  logic  wb_valid_i,
   input  reg_t  wb_rd_i,
   input  data_t wb_data_i,
   input  logic  wb_hilo_valid_i,
   input  data_t wb_lo_i,
   input  data_t wb_hi_i,
   output logic  wb_err_o
);

   data_t gpr_q [1:NUM_GPR];
   data_t gpr_d [1:NUM_GPR];
   data_t lo_q, lo_d;
   data_t hi_q, hi_d;

   pend_t pend_q [1:NUM_GPR];
   pend_t pend_d [1:NUM_GPR];
   pend_t hilo_pend_q, hilo_pend_d;

   logic  wb_err_q, wb_err_d;

   // Post-writeback view of every register number, used by reads and queries
   data_t eff_data [0:31];
   logic  eff_busy [0:31];
   pend_t eff_pend [0:31];
   pend_t hilo_eff;
   logic  wb_gpr;
   logic  hilo_dec;

   assign wb_gpr   = wb_valid_i && is_gpr(wb_rd_i);
   assign hilo_dec = wb_hilo_valid_i && (hilo_pend_q != '0);

   always_comb begin
      hilo_eff = hilo_dec ? hilo_pend_q - pend_t'(1) : hilo_pend_q;
      for (int r = 0; r < 32; r++) begin
         eff_data[r] = '0;
         eff_busy[r] = 1'b0;
         eff_pend[r] = '0;
      end
      for (int r = 1; r <= NUM_GPR; r++) begin
         if (wb_gpr && (wb_rd_i == REG_W'(r))) begin
            eff_data[r] = wb_data_i;
            eff_pend[r] = (pend_q[r] != '0) ? pend_q[r] - pend_t'(1)
                                            : pend_q[r];
         end else begin
            eff_data[r] = gpr_q[r];
            eff_pend[r] = pend_q[r];
         end
         eff_busy[r] = (eff_pend[r] != '0);
      end
      eff_data[30] = wb_hilo_valid_i ? wb_lo_i : lo_q;
      eff_data[31] = wb_hilo_valid_i ? wb_hi_i : hi_q;
      eff_busy[30] = (hilo_eff != '0);
      eff_busy[31] = (hilo_eff != '0);
   end

   assign rs_data_o = eff_data[rs_i];
   assign rt_data_o = eff_data[rt_i];
   assign rs_busy_o = eff_busy[rs_i];
   assign rt_busy_o = eff_busy[rt_i];

   assign rd_full_o   = is_gpr(chk_rd_i) &&
                        (eff_pend[chk_rd_i] == PEND_W'(MAX_PEND));
   assign hilo_full_o = (hilo_eff == PEND_W'(MAX_PEND));

   always_comb begin
      wb_err_d = wb_err_q;
      for (int r = 1; r <= NUM_GPR; r++) begin
         gpr_d[r]  = eff_data[r];
         pend_d[r] = eff_pend[r] +
                     pend_t'(inc_rd_en_i && (inc_rd_i == REG_W'(r)));
      end
      lo_d        = eff_data[30];
      hi_d        = eff_data[31];
      hilo_pend_d = hilo_eff + pend_t'(inc_hilo_i);
      // A writeback nobody was waiting for still lands, but is flagged
      if (wb_gpr && (eff_pend[wb_rd_i] == pend_q[wb_rd_i])
                 && (pend_q[wb_rd_i] == '0)) begin
         wb_err_d = 1'b1;
      end
      if (wb_hilo_valid_i && (hilo_pend_q == '0)) begin
         wb_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r <= NUM_GPR; r++) begin
            gpr_q[r]  <= '0;
            pend_q[r] <= '0;
         end
         lo_q        <= '0;
         hi_q        <= '0;
         hilo_pend_q <= '0;
         wb_err_q    <= 1'b0;
      end else begin
         for (int r = 1; r <= NUM_GPR; r++) begin
            gpr_q[r]  <= gpr_d[r];
            pend_q[r] <= pend_d[r];
         end
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         hilo_pend_q <= hilo_pend_d;
         wb_err_q    <= wb_err_d;
      end
   end

   assign wb_err_o = wb_err_q;

endmodule

// File: rtl/operand_fetch_stage.sv
// Register-fetch stage: RAW stall via scoreboard, one-deep output register.
// Ports: in_* decoded instr, out_* issued instr, wb_* writebacks, wb_err.
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic              in_wr_rd,
   input  logic              in_wr_hilo,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rs_data,
   output logic [DATA_W-1:0] out_rt_data,
   output logic [4:0]        out_rd,
   output logic              out_wr_rd,
   output logic              out_wr_hilo,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              wb_valid,
   input  logic [4:0]        wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              wb_hilo_valid,
   input  logic [DATA_W-1:0] wb_lo,
   input  logic [DATA_W-1:0] wb_hi,
   output logic              wb_err
);

   out_state_e state_q, state_d;
   issue_t     out_q, out_d;
   issue_t     issue;

   data_t rs_data, rt_data;
   logic  rs_busy, rt_busy;
   logic  rd_full, hilo_full;
   logic  hold_out;
   logic  accept;
   logic  inc_rd_en;

   reg_scoreboard_file u_sb (
      .clk             (clk),
      .rst_n           (rst_n),
      .rs_i            (in_rs),
      .rt_i            (in_rt),
      .rs_data_o       (rs_data),
      .rt_data_o       (rt_data),
      .rs_busy_o       (rs_busy),
      .rt_busy_o       (rt_busy),
      .chk_rd_i        (in_rd),
      .rd_full_o       (rd_full),
      .hilo_full_o     (hilo_full),
      .inc_rd_en_i     (inc_rd_en),
      .inc_rd_i        (in_rd),
      .inc_hilo_i      (accept && in_wr_hilo),
      .wb_valid_i      (wb_valid),
      .wb_rd_i         (wb_rd),
      .wb_data_i       (wb_data),
      .wb_hilo_valid_i (wb_hilo_valid),
      .wb_lo_i         (wb_lo),
      .wb_hi_i         (wb_hi),
      .wb_err_o        (wb_err)
   );

   assign out_valid = (state_q == OUT_FULL);
   assign hold_out  = out_valid && !out_ready;

   // Independent of in_valid so upstream may wait on it
   assign in_ready = !rs_busy && !rt_busy &&
                     !(in_wr_rd && rd_full) &&
                     !(in_wr_hilo && hilo_full) &&
                     !hold_out;

   assign accept    = in_valid && in_ready;
   assign inc_rd_en = accept && in_wr_rd && is_gpr(in_rd);

   always_comb begin
      issue.ctrl    = in_ctrl;
      issue.rs_data = rs_data;
      issue.rt_data = rt_data;
      issue.rd      = in_rd;
      issue.wr_rd   = in_wr_rd;
      issue.wr_hilo = in_wr_hilo;
   end

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      unique case (state_q)
         OUT_EMPTY: begin
            if (accept) begin
               state_d = OUT_FULL;
               out_d   = issue;
            end
         end
         OUT_FULL: begin
            // accept here implies out_ready, so the slot is reloaded
            if (accept) begin
               out_d = issue;
            end else if (out_ready) begin
               state_d = OUT_EMPTY;
            end
         end
         default: state_d = OUT_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OUT_EMPTY;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   assign out_rs_data = out_q.rs_data;
   assign out_rt_data = out_q.rt_data;
   assign out_rd      = out_q.rd;
   assign out_wr_rd   = out_q.wr_rd;
   assign out_wr_hilo = out_q.wr_hilo;
   assign out_ctrl    = out_q.ctrl;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed-vector bench for operand_fetch_stage.
// One task per scenario, inline comparisons, single summary line.
module tb_operand_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic        in_wr_rd, in_wr_hilo;
   logic [15:0] in_ctrl;
   logic        out_valid, out_ready;
   logic [31:0] out_rs_data, out_rt_data;
   logic [4:0]  out_rd;
   logic        out_wr_rd, out_wr_hilo;
   logic [15:0] out_ctrl;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_hilo_valid;
   logic [31:0] wb_lo, wb_hi;
   logic        wb_err;

   int vec  = 0;
   int errs = 0;

   always #5 clk = ~clk;

   operand_fetch_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rs         (in_rs),
      .in_rt         (in_rt),
      .in_rd         (in_rd),
      .in_wr_rd      (in_wr_rd),
      .in_wr_hilo    (in_wr_hilo),
      .in_ctrl       (in_ctrl),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_rs_data   (out_rs_data),
      .out_rt_data   (out_rt_data),
      .out_rd        (out_rd),
      .out_wr_rd     (out_wr_rd),
      .out_wr_hilo   (out_wr_hilo),
      .out_ctrl      (out_ctrl),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .wb_hilo_valid (wb_hilo_valid),
      .wb_lo         (wb_lo),
      .wb_hi         (wb_hi),
      .wb_err        (wb_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid      = 1'b0;
      in_rs         = '0;
      in_rt         = '0;
      in_rd         = '0;
      in_wr_rd      = 1'b0;
      in_wr_hilo    = 1'b0;
      in_ctrl       = '0;
      out_ready     = 1'b1;
      wb_valid      = 1'b0;
      wb_rd         = '0;
      wb_data       = '0;
      wb_hilo_valid = 1'b0;
      wb_lo         = '0;
      wb_hi         = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      #3;
      vec++; if (out_valid !== 1'b0) begin errs++;
         $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
      vec++; if (out_rs_data !== 32'h0) begin errs++;
         $display("FAIL rst_out_rs got %h exp 0", out_rs_data); end
      vec++; if (wb_err !== 1'b0) begin errs++;
         $display("FAIL rst_wb_err got %0b exp 0", wb_err); end
      #9;
      rst_n = 1'b1;
      tick();
      vec++; if (in_ready !== 1'b1) begin errs++;
         $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
   endtask

   task automatic test_bare_wb();
      idle();
      wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
      tick();
      wb_valid = 1'b0;
      #1;
      vec++; if (wb_err !== 1'b1) begin errs++;
         $display("FAIL bare_wb_err got %0b exp 1", wb_err); end
      in_valid = 1'b1; in_rs = 5'd5; in_rt = 5'd0; in_ctrl = 16'h0101;
      #1;
      vec++; if (in_ready !== 1'b1) begin errs++;
         $display("FAIL bare_in_ready got %0b exp 1", in_ready); end
      vec++; if (out_valid !== 1'b0) begin errs++;
         $display("FAIL bare_pre_valid got %0b exp 0", out_valid); end
      tick();
      in_valid = 1'b0;
      #1;
      vec++; if (out_valid !== 1'b1) begin errs++;
         $display("FAIL bare_out_valid got %0b exp 1", out_valid); end
      vec++; if (out_rs_data !== 32'h1234) begin errs++;
         $display("FAIL bare_rs got %h exp 1234", out_rs_data); end
      vec++; if (out_rt_data !== 32'h0) begin errs++;
         $display("FAIL bare_rt got %h exp 0", out_rt_data); end
      vec++; if (out_ctrl !== 16'h0101) begin errs++;
         $display("FAIL bare_ctrl got %h exp 0101", out_ctrl); end
      tick();
      vec++; if (out_valid !== 1'b0) begin errs++;
         $display("FAIL bare_drain got %0b exp 0", out_valid); end
   endtask

   task automatic test_raw();
      idle();
      in_valid = 1'b1; in_rd = 5'd7; in_wr_rd = 1'b1;
      tick();
      in_rd = 5'd0; in_wr_rd = 1'b0; in_rs = 5'd7; in_ctrl = 16'h0202;
      #1;
      vec++; if (in_ready !== 1'b0) begin errs++;
         $display("FAIL raw_stall got %0b exp 0", in_ready); end
      tick();
      vec++; if (out_valid !== 1'b0) begin errs++;
         $display("FAIL raw_bubble got %0b exp 0", out_valid); end
      vec++; if (in_ready !== 1'b0) begin errs++;
         $display("FAIL raw_stall2 got %0b exp 0", in_ready); end
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5;
      #1;
      vec++; if (in_ready !== 1'b1) begin errs++;
         $display("FAIL raw_bypass_ready got %0b exp 1", in_ready); end
      tick();
      in_valid = 1'b0; wb_valid = 1'b0;
      #1;
      vec++; if (out_valid !== 1'b1) begin errs++;
         $display("FAIL raw_valid got %0b exp 1", out_valid); end
      vec++; if (out_rs_data !== 32'hA5) begin errs++;
         $display("FAIL raw_rs got %h exp a5", out_rs_data); end
      vec++; if (out_ctrl !== 16'h0202) begin errs++;
         $display("FAIL raw_ctrl got %h exp 0202", out_ctrl); end
      tick();
   endtask

   task automatic test_pend_full();
      idle();
      in_valid = 1'b1; in_rd = 5'd3; in_wr_rd = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         vec++; if (in_ready !== 1'b1) begin errs++;
            $display("FAIL pend_fill%0d got %0b exp 1", i, in_ready); end
         tick();
      end
      #1;
      vec++; if (in_ready !== 1'b0) begin errs++;
         $display("FAIL pend_full got %0b exp 0", in_ready); end
      tick();
      vec++; if (in_ready !== 1'b0) begin errs++;
         $display("FAIL pend_full2 got %0b exp 0", in_ready); end
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h31;
      #1;
      vec++; if (in_ready !== 1'b1) begin errs++;
         $display("FAIL pend_release got %0b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wb_data = 32'h32 + 32'(i);
         tick();
      end
      wb_valid = 1'b0;
      in_rd = 5'd0; in_wr_rd = 1'b0; in_rs = 5'd3;
      #1;
      vec++; if (in_ready !== 1'b0) begin errs++;
         $display("FAIL pend_one_left got %0b exp 0", in_ready); end
      wb_valid = 1'b1; wb_data = 32'h66; in_valid = 1'b1;
      #1;
      vec++; if (in_ready !== 1'b1) begin errs++;
         $display("FAIL pend_last_wb got %0b exp 1", in_ready); end
      tick();
      wb_valid = 1'b0; in_valid = 1'b0;
      #1;
      vec++; if (out_rs_data !== 32'h66) begin errs++;
         $display("FAIL pend_rs got %h exp 66", out_rs_data); end
      tick();
      vec++; if (in_ready !== 1'b1) begin errs++;
         $display("FAIL pend_zero got %0b exp 1", in_ready); end
   endtask

   task automatic test_hilo();
      idle();
      in_valid = 1'b1; in_wr_hilo = 1'b1;
      #1;
      vec++; if (in_ready !== 1'b1) begin errs++;
         $display("FAIL hilo_issue got %0b exp 1", in_ready); end
      tick();
      in_wr_hilo = 1'b0; in_rs = 5'd30;
      #1;
      vec++; if (in_ready !== 1'b0) begin errs++;
         $display("FAIL hilo_stall got %0b exp 0", in_ready); end
      tick();
      vec++; if (in_ready !== 1'b0) begin errs++;
         $display("FAIL hilo_stall2 got %0b exp 0", in_ready); end
      wb_hilo_valid = 1'b1; wb_lo = 32'h1; wb_hi = 32'h2;
      #1;
      vec++; if (in_ready !== 1'b1) begin errs++;
         $display("FAIL hilo_bypass got %0b exp 1", in_ready); end
      tick();
      wb_hilo_valid = 1'b0; in_rs = 5'd0; in_rt = 5'd31;
      #1;
      vec++; if (out_rs_data !== 32'h1) begin errs++;
         $display("FAIL hilo_lo got %h exp 1", out_rs_data); end
      vec++; if (in_ready !== 1'b1) begin errs++;
         $display("FAIL hilo_free got %0b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      #1;
      vec++; if (out_rt_data !== 32'h2) begin errs++;
         $display("FAIL hilo_hi got %h exp 2", out_rt_data); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] expc;
      idle();
      out_ready = 1'b0;
      in_valid = 1'b1; in_rs = 5'd5; in_ctrl = 16'hBEEF;
      tick();
      in_rs = 5'd7; in_ctrl = 16'hC001;
      for (int i = 0; i < 3; i++) begin
         #1;
         vec++; if (in_ready !== 1'b0) begin errs++;
            $display("FAIL bp_ready%0d got %0b exp 0", i, in_ready); end
         vec++; if (out_valid !== 1'b1 || out_rs_data !== 32'h1234 ||
                    out_ctrl !== 16'hBEEF) begin errs++;
            $display("FAIL bp_hold%0d got %0b/%h/%h exp 1/1234/beef",
                     i, out_valid, out_rs_data, out_ctrl); end
         tick();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         expc = 16'hC001 + 16'(k);
         in_ctrl = expc;
         #1;
         vec++; if (in_ready !== 1'b1) begin errs++;
            $display("FAIL b2b_ready%0d got %0b exp 1", k, in_ready); end
         tick();
         vec++; if (out_valid !== 1'b1 || out_ctrl !== expc ||
                    out_rs_data !== 32'hA5) begin errs++;
            $display("FAIL b2b_out%0d got %0b/%h/%h exp 1/%h/a5",
                     k, out_valid, out_ctrl, out_rs_data, expc); end
      end
      in_valid = 1'b0;
      tick();
      vec++; if (out_valid !== 1'b0) begin errs++;
         $display("FAIL b2b_drain got %0b exp 0", out_valid); end
   endtask

   task automatic test_reset_mid();
      idle();
      in_valid = 1'b1; in_rd = 5'd4; in_wr_rd = 1'b1; in_ctrl = 16'h4444;
      tick();
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      vec++; if (out_valid !== 1'b1) begin errs++;
         $display("FAIL mid_pre_valid got %0b exp 1", out_valid); end
      in_rs = 5'd4; in_rd = 5'd0; in_wr_rd = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      vec++; if (out_valid !== 1'b0 || out_rd !== 5'd0 ||
                 out_wr_rd !== 1'b0 || out_ctrl !== 16'h0) begin errs++;
         $display("FAIL mid_rst_out got %0b/%0d/%0b/%h exp 0/0/0/0",
                  out_valid, out_rd, out_wr_rd, out_ctrl); end
      vec++; if (wb_err !== 1'b0) begin errs++;
         $display("FAIL mid_rst_err got %0b exp 0", wb_err); end
      vec++; if (in_ready !== 1'b1) begin errs++;
         $display("FAIL mid_rst_pend got %0b exp 1", in_ready); end
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      in_rs = 5'd5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      vec++; if (out_rs_data !== 32'h0) begin errs++;
         $display("FAIL mid_r5_clr got %h exp 0", out_rs_data); end
      in_valid = 1'b1; in_rs = 5'd0; in_rd = 5'd31; in_wr_rd = 1'b1;
      tick();
      in_valid = 1'b0; in_rd = 5'd0; in_wr_rd = 1'b0; in_rs = 5'd31;
      #1;
      vec++; if (in_ready !== 1'b1) begin errs++;
         $display("FAIL mid_rd31 got %0b exp 1", in_ready); end
      wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
      tick();
      wb_valid = 1'b0;
      #1;
      vec++; if (wb_err !== 1'b1) begin errs++;
         $display("FAIL mid_late_wb got %0b exp 1", wb_err); end
   endtask

   initial begin
      test_reset();
      test_bare_wb();
      test_raw();
      test_pend_full();
      test_hilo();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
